// File: rtl/dma_pkg.sv
// Shared DMA types, default build widths and 4 KB boundary constant.
// Used by dma_streamer and dma_burst_calc.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif
`ifndef DMA_MAX_BEAT_BURST
`define DMA_MAX_BEAT_BURST 256
`endif

package dma_pkg;

  localparam int unsigned DMA_4K_BOUNDARY = 4096;
  localparam int unsigned DMA_AXI_STRB_W  = `DMA_DATA_WIDTH / 8;
  localparam int unsigned DMA_FIFO_SZ_W   = 10;

  typedef enum logic [1:0] {
    DMA_ST_IDLE = 2'd0,
    DMA_ST_RUN  = 2'd1,
    DMA_ST_DONE = 2'd2
  } dma_st_t;

  typedef enum logic {
    DMA_NO_ERR        = 1'b0,
    DMA_UNALIGNED_ERR = 1'b1
  } dma_err_src_t;

  typedef logic [DMA_FIFO_SZ_W-1:0] fifo_sz_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic [31:0]               addr;
    logic [7:0]                alen;
    logic [2:0]                size;
    logic [DMA_AXI_STRB_W-1:0] strb;
    logic                      valid;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;

  typedef struct packed {
    logic [31:0]  addr;
    dma_err_src_t src;
    logic         valid;
  } s_dma_error_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: min(remaining beats, MAX_BEATS, beats to 4 KB)
// plus write strobe. Tail masking is enabled by `DMA_STRB_TAIL_EN.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DMA_DATA_WIDTH,
  parameter int unsigned MAX_BEATS  = `DMA_MAX_BEAT_BURST
) (
  input  logic [11:0]                     addr_lo_i,
  input  logic [31:0]                     rem_beats_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] tail_i,
  output logic [8:0]                      burst_o,
  output logic [DATA_WIDTH/8-1:0]         strb_o
);

  localparam int unsigned BPB = DATA_WIDTH / 8;
  localparam int unsigned SZ  = $clog2(BPB);

  logic [12:0] bytes_to_4k;
  logic [12:0] beats_to_4k;
  logic [31:0] lim;
  logic [22:0] unused_lim_hi;

`ifdef DMA_STRB_TAIL_EN
  logic [BPB-1:0] tail_mask;
`endif

  always_comb begin
    bytes_to_4k = 13'(DMA_4K_BOUNDARY) - {1'b0, addr_lo_i};
    beats_to_4k = bytes_to_4k >> SZ;
    lim = rem_beats_i;
    if (32'(MAX_BEATS) < lim) lim = 32'(MAX_BEATS);
    if ({19'd0, beats_to_4k} < lim) lim = {19'd0, beats_to_4k};
    burst_o = lim[8:0];
    strb_o  = '1;
`ifdef DMA_STRB_TAIL_EN
    // Only the burst that drains the descriptor carries the partial strobe
    tail_mask = '1;
    tail_mask = tail_mask << tail_i;
    if ((lim == rem_beats_i) && (tail_i != '0)) strb_o = ~tail_mask;
`endif
  end

  assign unused_lim_hi = lim[31:9];

`ifndef DMA_STRB_TAIL_EN
  logic unused_tail;
  assign unused_tail = ^tail_i;
`endif

endmodule

// File: rtl/dma_streamer.sv
// Splits a DMA descriptor into AXI-legal, FIFO-gated burst requests.
// `DMA_STRB_TAIL_EN allows non-beat-multiple lengths with a masked final strobe.
module dma_streamer
  import dma_pkg::*;
#(
  parameter int unsigned STREAM_TYPE = 0,
  parameter int unsigned DATA_WIDTH  = `DMA_DATA_WIDTH,
  parameter int unsigned MAX_BEATS   = `DMA_MAX_BEAT_BURST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dma_go_i,
  input  logic            dma_abort_i,
  input  s_dma_desc_t     dma_desc_i,
  input  fifo_sz_t        fifo_avail_i,
  output s_dma_axi_req_t  dma_axi_req_o,
  input  s_dma_axi_resp_t dma_axi_resp_i,
  output logic            dma_active_o,
  output logic            dma_done_o,
  output s_dma_error_t    dma_error_o
);

  localparam int unsigned BPB = DATA_WIDTH / 8;
  localparam int unsigned SZ  = $clog2(BPB);

  dma_st_t        state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    rem_q, rem_d;
  logic [SZ-1:0]  tail_q, tail_d;
  s_dma_axi_req_t req_q, req_d;
  s_dma_error_t   err_q, err_d;
  logic           active_q, active_d;
  logic           done_q, done_d;

  logic [8:0]     burst;
  logic [BPB-1:0] strb;
  logic [31:0]    start_addr;
  logic [31:0]    hs_beats;

  dma_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_burst_calc (
    .addr_lo_i   (addr_q[11:0]),
    .rem_beats_i (rem_q),
    .tail_i      (tail_q),
    .burst_o     (burst),
    .strb_o      (strb)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tail_d     = tail_q;
    req_d      = req_q;
    err_d      = err_q;
    start_addr = (STREAM_TYPE == 1) ? dma_desc_i.dst_addr : dma_desc_i.src_addr;
    hs_beats   = {24'd0, req_q.alen} + 32'd1;

    unique case (state_q)
      DMA_ST_IDLE: begin
        if (dma_go_i) begin
          addr_d = start_addr;
          rem_d  = (dma_desc_i.num_bytes >> SZ) + 32'(|dma_desc_i.num_bytes[SZ-1:0]);
          tail_d = dma_desc_i.num_bytes[SZ-1:0];
          err_d  = '0;
          if (start_addr[SZ-1:0] != '0) begin
            err_d = '{addr: start_addr, src: DMA_UNALIGNED_ERR, valid: 1'b1};
            state_d = DMA_ST_DONE;
          end
`ifndef DMA_STRB_TAIL_EN
          else if (dma_desc_i.num_bytes[SZ-1:0] != '0) begin
            err_d = '{addr: start_addr, src: DMA_UNALIGNED_ERR, valid: 1'b1};
            state_d = DMA_ST_DONE;
          end
`endif
          else if (dma_desc_i.num_bytes == '0) begin
            state_d = DMA_ST_DONE;
          end else begin
            state_d = DMA_ST_RUN;
          end
        end
      end

      DMA_ST_RUN: begin
        if (req_q.valid) begin
          // Abort never cuts a pending handshake short; it only suppresses done
          if (dma_axi_resp_i.ready) begin
            req_d.valid = 1'b0;
            addr_d      = addr_q + (hs_beats << SZ);
            rem_d       = rem_q - hs_beats;
            if (dma_abort_i)         state_d = DMA_ST_IDLE;
            else if (rem_d == '0)    state_d = DMA_ST_DONE;
          end
        end else if (dma_abort_i) begin
          state_d = DMA_ST_IDLE;
        end else if (fifo_avail_i >= fifo_sz_t'(burst)) begin
          req_d.addr  = addr_q;
          req_d.alen  = 8'(burst - 9'd1);
          req_d.size  = 3'(SZ);
          req_d.strb  = strb;
          req_d.valid = 1'b1;
        end
      end

      DMA_ST_DONE: state_d = DMA_ST_IDLE;

      default: state_d = DMA_ST_IDLE;
    endcase

    active_d = (state_d != DMA_ST_IDLE);
    done_d   = (state_d == DMA_ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DMA_ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      tail_q   <= '0;
      req_q    <= '0;
      err_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tail_q   <= tail_d;
      req_q    <= req_d;
      err_q    <= err_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign dma_axi_req_o = req_q;
  assign dma_active_o  = active_q;
  assign dma_done_o    = done_q;
  assign dma_error_o   = err_q;

endmodule

// File: doc/dma_streamer.md
# dma_streamer

Splits one DMA descriptor into a sequence of AXI-legal burst requests for one direction of the DMA engine. One instance serves the read side, using the source address. A second instance serves the write side, using the destination address. Sits between the DMA FSM/CSR (descriptor, go, done, error) and the DMA AXI interface (`s_dma_axi_req_t` / `s_dma_axi_resp_t`). It gates each burst on FIFO availability, so a read burst never overruns the FIFO and a write burst never underruns it.

## Interface
- `STREAM_TYPE`, default 0: 0 = read streamer (uses `src_addr`), 1 = write streamer (uses `dst_addr`).
- `DATA_WIDTH`, default `` `DMA_DATA_WIDTH ``: AXI data width; BPB = `DATA_WIDTH/8` bytes per beat.
- `MAX_BEATS`, default `` `DMA_MAX_BEAT_BURST ``: maximum beats per burst, 1..256.
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dma_go_i`  in  1  single-cycle start pulse; ignored unless the FSM is in IDLE.
- `dma_abort_i`  in  1  level; stops issuing new bursts.
- `dma_desc_i`  in  `s_dma_desc_t`  descriptor; sampled only on an accepted go.
- `fifo_avail_i`  in  `fifo_sz_t`  read streamer: free FIFO entries; write streamer: occupied FIFO entries.
- `dma_axi_req_o`  out  `s_dma_axi_req_t`  burst request: addr, alen, size, strb, valid.
- `dma_axi_resp_i`  in  `s_dma_axi_resp_t`  ready for the request.
- `dma_active_o`  out  1  high while not in IDLE.
- `dma_done_o`  out  1  one-cycle pulse at the end of a descriptor (normal or error).
- `dma_error_o`  out  `s_dma_error_t`  sticky alignment error; cleared on the next accepted go.

## Operation
- FSM uses `dma_st_t`: IDLE -> RUN -> DONE -> IDLE.
- **IDLE + go:**
  - Latch addr = src/dst per STREAM_TYPE.
  - Latch rem_beats = ceil(num_bytes/BPB).
  - Latch tail = num_bytes mod BPB.
  - Clear the error register.
- **Go checks, in priority order:**
  - addr not BPB-aligned: set the error (src `DMA_UNALIGNED_ERR`, addr = offending address, valid = 1) and go to DONE.
  - num_bytes == 0: go to DONE with no request.
  - Otherwise go to RUN.
- **Burst length in RUN:** burst = min(rem_beats, MAX_BEATS, beats_to_4k).
  - beats_to_4k = (4096 − addr[11:0]) / BPB.
  - All arithmetic runs at 13 bits for 4 KB math and 32 bits for addr/bytes. No wrap: addresses are unsigned and increment only.
- **Issuing a burst (RUN, no request pending):** if fifo_avail_i ≥ burst and abort is low, register the request:
  - addr = current address.
  - alen = burst − 1.
  - size = log2(BPB).
  - strb = all ones, except the final burst of the descriptor when tail ≠ 0, where strb = (1<<tail) − 1. This applies to the last beat only.
  - valid = 1.
- **Request handshake:** once valid is high, every request field holds stable until valid & ready.
- **On valid & ready:**
  - valid drops.
  - addr += burst·BPB.
  - rem_beats −= burst.
  - If rem_beats reaches 0, go to DONE.
- **Abort:**
  - No request pending: go to IDLE next cycle, no done pulse.
  - Request pending: finish that handshake, then go to IDLE, no done pulse.
- **DONE:** `dma_done_o` = 1 for exactly one cycle, then IDLE.
- **Reset mid-operation:** FSM to IDLE; all request fields, valid, done, active and the error register go to 0.

## Timing
- Reset values: every output is 0.
- Go sampled at edge N: RUN from N+1; earliest valid = 1 from N+2 (outputs registered).
- Back-to-back bursts: the next valid rises no earlier than 1 cycle after the previous handshake.
- Last handshake at edge M: done is high during cycle M+1; active falls at M+2.
- Error path: go at N; error valid and done both high from N+1; valid never rises.
- A go that arrives in RUN or DONE is dropped silently.

## Configuration
- `DMA_STRB_TAIL_EN` defined:
  - num_bytes not a multiple of BPB is legal.
  - The final burst carries a masked strb as above.
- `DMA_STRB_TAIL_EN` undefined:
  - num_bytes mod BPB ≠ 0 is flagged as `DMA_UNALIGNED_ERR` (addr = start address) at go, handled like the address-alignment error.
  - strb is always all ones.

## Structure
- Already in `dma_pkg`: `dma_st_t`, `s_dma_desc_t`, `s_dma_axi_req_t`, `s_dma_axi_resp_t`, `s_dma_error_t`, `fifo_sz_t`.
- Add to `dma_pkg`: localparam `DMA_4K_BOUNDARY = 4096`.
- One sub-module: `dma_burst_calc`, a combinational min(rem, MAX_BEATS, beats_to_4k) plus strb generation. It is shared by both streamer instances.

## Test plan
BPB = 8, MAX_BEATS = 256.
- **4 KB transfer:** go at 0x1000, 4096 B, fifo_avail = 256 -> two requests, 0x1000/alen = 255 then 0x1800/alen = 255, both size = 3 and strb = 0xFF; one done pulse; no error.
- **4 KB boundary split:** 0x0FF0, 64 B -> 0x0FF0/alen = 1, then 0x1000/alen = 5.
- **Backpressure and FIFO gating:**
  - ready held low for 5 cycles -> all request fields stable.
  - fifo_avail = 3 with burst = 8 -> valid stays low until avail = 8, then rises the next cycle.
- **Errors:**
  - Address 0x1004 -> error {addr = 0x1004, src = UNALIGNED, valid = 1} and done at N+1; valid never rises.
  - num_bytes = 0 -> done only, no error.
- **Tail strobe:** 13 B at 0x2000 -> with `DMA_STRB_TAIL_EN`: alen = 1, strb = 0x1F; without it: unaligned error, no request.
- **Abort and reset:**
  - Abort with valid pending -> handshake completes, IDLE, no done.
  - rst_n asserted in RUN -> all outputs 0 immediately.
